// File: rtl/tuner_sweep_ctrl.sv
// tuner_sweep_ctrl: steps a ring tuning code across a range, reads detected power per code,
// and reports the code giving minimum (thru port) or maximum (drop port) power.
module tuner_sweep_ctrl #(
  parameter int ADC_WIDTH    = 8,
  parameter int DAC_WIDTH    = 8,
  parameter int SettleCycles = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sweep_start,
  input  logic                 i_abort,
  input  logic                 i_search_max,
  input  logic [DAC_WIDTH-1:0] i_code_start,
  input  logic [DAC_WIDTH-1:0] i_code_end,
  input  logic [DAC_WIDTH-1:0] i_code_step,
  output logic [DAC_WIDTH-1:0] o_dig_tune_code,
  output logic                 o_dig_pwr_read_val,
  input  logic                 i_dig_pwr_read_rdy,
  input  logic                 i_dig_pwr_detect_val,
  output logic                 o_dig_pwr_detect_rdy,
  input  logic [ADC_WIDTH-1:0] i_dig_ring_pwr_detected,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DAC_WIDTH-1:0] o_peak_code,
  output logic [ADC_WIDTH-1:0] o_peak_pwr
);
  typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, UPDATE, DONE} state_e;
  state_e state_q, state_d;
  logic [DAC_WIDTH-1:0] code_q, code_d, end_q, end_d, step_q, step_d;
  logic [DAC_WIDTH-1:0] best_code_q, best_code_d, peak_code_q, peak_code_d;
  logic [ADC_WIDTH-1:0] best_pwr_q, best_pwr_d, peak_pwr_q, peak_pwr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 mode_q, mode_d, have_best_q, have_best_d;
  logic                 read_val_q, read_val_d, detect_rdy_q, detect_rdy_d;
  logic [DAC_WIDTH:0]   next_code;
  logic                 last, better;

  // one extra bit so a step past the top of the DAC range ends the sweep instead of wrapping
  assign next_code = {1'b0, code_q} + {1'b0, step_q};
  assign last      = (code_q >= end_q) || (next_code > {1'b0, end_q}) || next_code[DAC_WIDTH];
  assign better    = !have_best_q || (mode_q ? i_dig_ring_pwr_detected > best_pwr_q
                                             : i_dig_ring_pwr_detected < best_pwr_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && i_abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = i_sweep_start ? SETTLE : IDLE;
        SETTLE:  state_d = (cnt_q <= 8'd1) ? REQ : SETTLE;
        REQ:     state_d = (read_val_q && i_dig_pwr_read_rdy) ? WAIT : REQ;
        WAIT:    state_d = (detect_rdy_q && i_dig_pwr_detect_val) ? UPDATE : WAIT;
        UPDATE:  state_d = last ? DONE : SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    code_d       = code_q;
    end_d        = end_q;
    step_d       = step_q;
    mode_d       = mode_q;
    cnt_d        = (state_q == SETTLE) ? cnt_q - 8'd1 : cnt_q;
    have_best_d  = have_best_q;
    best_code_d  = best_code_q;
    best_pwr_d   = best_pwr_q;
    peak_code_d  = peak_code_q;
    peak_pwr_d   = peak_pwr_q;
    read_val_d   = state_d == REQ;
    detect_rdy_d = state_d == WAIT;
    if (state_q == IDLE && i_sweep_start) begin
      code_d      = i_code_start;
      end_d       = i_code_end;
      step_d      = (i_code_step == '0) ? DAC_WIDTH'(1) : i_code_step;
      mode_d      = i_search_max;
      cnt_d       = 8'(SettleCycles);
      have_best_d = 1'b0;
    end
    if (state_q == WAIT && state_d == UPDATE) begin
      have_best_d = 1'b1;
      best_code_d = better ? code_q : best_code_q;
      best_pwr_d  = better ? i_dig_ring_pwr_detected : best_pwr_q;
    end
    if (state_q == UPDATE && state_d == SETTLE) begin
      code_d = next_code[DAC_WIDTH-1:0];
      cnt_d  = 8'(SettleCycles);
    end
    if (state_d == DONE) begin
      code_d      = best_code_q;
      peak_code_d = best_code_q;
      peak_pwr_d  = best_pwr_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q       <= '0;
      end_q        <= '0;
      step_q       <= '0;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      have_best_q  <= 1'b0;
      best_code_q  <= '0;
      best_pwr_q   <= '0;
      peak_code_q  <= '0;
      peak_pwr_q   <= '0;
      read_val_q   <= 1'b0;
      detect_rdy_q <= 1'b0;
    end else begin
      code_q       <= code_d;
      end_q        <= end_d;
      step_q       <= step_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      have_best_q  <= have_best_d;
      best_code_q  <= best_code_d;
      best_pwr_q   <= best_pwr_d;
      peak_code_q  <= peak_code_d;
      peak_pwr_q   <= peak_pwr_d;
      read_val_q   <= read_val_d;
      detect_rdy_q <= detect_rdy_d;
    end
  end

  assign o_dig_tune_code      = code_q;
  assign o_dig_pwr_read_val   = read_val_q;
  assign o_dig_pwr_detect_rdy = detect_rdy_q;
  assign o_busy               = state_q != IDLE;
  assign o_done               = state_q == DONE;
  assign o_peak_code          = peak_code_q;
  assign o_peak_pwr           = peak_pwr_q;
endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// tb_tuner_sweep_ctrl: directed and random sweeps against a list-based reference of codes and best power.
module tb_tuner_sweep_ctrl;
  localparam int S = 4;
  logic       i_clk = 1'b0, i_rst, i_sweep_start, i_abort, i_search_max;
  logic [7:0] i_code_start, i_code_end, i_code_step, i_dig_ring_pwr_detected;
  logic       i_dig_pwr_read_rdy, i_dig_pwr_detect_val;
  logic [7:0] o_dig_tune_code, o_peak_code, o_peak_pwr;
  logic       o_dig_pwr_read_val, o_dig_pwr_detect_rdy, o_busy, o_done;
  int         errors = 0, checks = 0, done_cnt = 0;
  logic [7:0] pw [256];
  logic [7:0] pk_c, pk_p, code_h;
  int         d0;

  tuner_sweep_ctrl #(.ADC_WIDTH(8), .DAC_WIDTH(8), .SettleCycles(S)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sweep_start(i_sweep_start), .i_abort(i_abort),
    .i_search_max(i_search_max), .i_code_start(i_code_start), .i_code_end(i_code_end),
    .i_code_step(i_code_step), .o_dig_tune_code(o_dig_tune_code),
    .o_dig_pwr_read_val(o_dig_pwr_read_val), .i_dig_pwr_read_rdy(i_dig_pwr_read_rdy),
    .i_dig_pwr_detect_val(i_dig_pwr_detect_val), .o_dig_pwr_detect_rdy(o_dig_pwr_detect_rdy),
    .i_dig_ring_pwr_detected(i_dig_ring_pwr_detected), .o_busy(o_busy), .o_done(o_done),
    .o_peak_code(o_peak_code), .o_peak_pwr(o_peak_pwr)
  );

  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input int s, e, st, input bit m);
    @(negedge i_clk);
    i_sweep_start = 1'b1; i_search_max = m;
    i_code_start = 8'(s); i_code_end = 8'(e); i_code_step = 8'(st);
    @(negedge i_clk);
    i_sweep_start = 1'b0;
    i_code_start = 8'($urandom); i_code_end = 8'($urandom); i_code_step = 8'($urandom);
    i_search_max = 1'($urandom);
  endtask

  task automatic run(input int s, e, st, input bit m, input int rd, dd);
    int codes[$];
    int c, sv, bi, nhs, ns, rc, wc, settle, stab_bad, bad_code, db;
    logic [7:0] held;
    sv = (st == 0) ? 1 : st;
    c = s;
    codes.push_back(c);
    while (c < e && c + sv <= e) begin c += sv; codes.push_back(c); end
    bi = 0;
    for (int i = 1; i < codes.size(); i++) if (m ? pw[i] > pw[bi] : pw[i] < pw[bi]) bi = i;
    i_dig_pwr_read_rdy = 1'b0; i_dig_pwr_detect_val = 1'b0;
    db = done_cnt;
    launch(s, e, st, m);
    nhs = 0; ns = 0; rc = 0; wc = 0; settle = 0; stab_bad = 0; bad_code = 0; held = '0;
    for (int cyc = 0; cyc < 5000 && o_done !== 1'b1; cyc++) begin
      if (nhs == 0 && !o_dig_pwr_read_val) settle++;
      if (o_dig_pwr_read_val) begin
        if (rc == 0) held = o_dig_tune_code;
        else if (o_dig_tune_code !== held) stab_bad++;
        i_dig_pwr_read_rdy = rc >= rd;
        rc++;
        if (i_dig_pwr_read_rdy) begin
          if (nhs >= codes.size() || o_dig_tune_code !== 8'(codes[nhs])) bad_code++;
          nhs++;
        end
      end else begin
        i_dig_pwr_read_rdy = 1'($urandom);
        rc = 0;
      end
      if (o_dig_pwr_detect_rdy) begin
        if (o_dig_tune_code !== held) stab_bad++;
        i_dig_pwr_detect_val = wc >= dd;
        i_dig_ring_pwr_detected = pw[(nhs > 0) ? nhs - 1 : 0];
        wc++;
        if (i_dig_pwr_detect_val) ns++;
      end else begin
        // stray detect pulses carry an extreme value that would win if wrongly accepted
        i_dig_pwr_detect_val = 1'($urandom);
        i_dig_ring_pwr_detected = m ? 8'hFF : 8'h00;
        wc = 0;
      end
      @(negedge i_clk);
    end
    chk("done_seen", 32'(o_done), 1);
    chk("peak_code", 32'(o_peak_code), codes[bi]);
    chk("peak_pwr", 32'(o_peak_pwr), 32'(pw[bi]));
    chk("park_code", 32'(o_dig_tune_code), codes[bi]);
    chk("n_handshakes", nhs, codes.size());
    chk("n_samples", ns, codes.size());
    chk("settle_cycles", settle, S);
    chk("code_stable", stab_bad, 0);
    chk("code_sequence", bad_code, 0);
    i_dig_pwr_detect_val = 1'b0;
    @(negedge i_clk);
    chk("done_one_cycle", {o_done, o_busy}, 0);
    chk("done_count", done_cnt, db + 1);
    chk("park_hold", 32'(o_dig_tune_code), codes[bi]);
  endtask

  initial begin
    i_rst = 1'b1; i_sweep_start = 1'b0; i_abort = 1'b0; i_search_max = 1'b0;
    i_code_start = '0; i_code_end = '0; i_code_step = '0;
    i_dig_pwr_read_rdy = 1'b0; i_dig_pwr_detect_val = 1'b0; i_dig_ring_pwr_detected = '0;
    #1;
    chk("rst_vals", {o_dig_tune_code, o_peak_code, o_peak_pwr}, 0);
    chk("rst_ctrl", {o_dig_pwr_read_val, o_dig_pwr_detect_rdy, o_busy, o_done}, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;

    pw[0] = 90; pw[1] = 40; pw[2] = 20; pw[3] = 35; pw[4] = 80;
    run(10, 14, 1, 1'b0, 0, 0);
    chk("min_sweep_code", 32'(o_peak_code), 12);
    chk("min_sweep_pwr", 32'(o_peak_pwr), 20);

    pw[0] = 10; pw[1] = 50; pw[2] = 50; pw[3] = 30; pw[4] = 5;
    run(10, 14, 1, 1'b1, 0, 0);
    chk("tie_keeps_first", 32'(o_peak_code), 11);
    chk("max_sweep_pwr", 32'(o_peak_pwr), 50);

    for (int i = 0; i < 256; i++) pw[i] = 8'($urandom);
    run(250, 255, 4, 1'b0, 0, 1);
    run(7, 7, 0, 1'b1, 1, 0);
    run(9, 3, 2, 1'b0, 0, 0);
    run(10, 14, 1, 1'b0, 6, 3);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 256; i++) pw[i] = 8'($urandom_range(0, 15));
      run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 20),
          1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    pk_c = o_peak_code; pk_p = o_peak_pwr;
    i_dig_pwr_detect_val = 1'b0;
    launch(20, 30, 2, 1'b0);
    for (int k = 0; k < 100 && !o_dig_pwr_detect_rdy; k++) begin
      i_dig_pwr_read_rdy = 1'b1;
      @(negedge i_clk);
    end
    chk("reach_wait", 32'(o_dig_pwr_detect_rdy), 1);
    code_h = o_dig_tune_code; d0 = done_cnt;
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort_idle", {o_busy, o_dig_pwr_read_val, o_dig_pwr_detect_rdy}, 0);
    chk("abort_code_hold", 32'(o_dig_tune_code), 32'(code_h));
    chk("abort_peak", {o_peak_code, o_peak_pwr}, {pk_c, pk_p});
    @(negedge i_clk);
    chk("abort_no_done", done_cnt, d0);

    launch(40, 60, 3, 1'b1);
    chk("settle_busy", {o_busy, o_dig_pwr_read_val}, 2'b10);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_vals", {o_dig_tune_code, o_peak_code, o_peak_pwr}, 0);
    chk("mid_rst_ctrl", {o_dig_pwr_read_val, o_dig_pwr_detect_rdy, o_busy, o_done}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_no_done", done_cnt, d0);

    for (int i = 0; i < 256; i++) pw[i] = 8'($urandom);
    run(100, 130, 5, 1'b1, 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
